// File: rtl/moving_average_ctrl.sv
// moving_average_ctrl: validates window reconfiguration, flushes and warms up the
// moving_average filter, and gates its enable so out_valid marks only settled samples.
module moving_average_ctrl #(
    parameter int SIZE_WINDOW  = 7,
    parameter int MAX_WINDOW   = 64,
    parameter int PIPE_LAT     = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SIZE_WINDOW-1:0] cfg_window,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   cfg_error,
    input  logic                   in_valid,
    output logic                   filt_reset_n,
    output logic [SIZE_WINDOW-1:0] filt_window,
    output logic                   filt_enable,
    output logic                   out_valid,
    output logic                   busy,
    output logic [1:0]             state
);
    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, WARMUP = 2'd2, RUN = 2'd3} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SIZE_WINDOW-1:0] win_q, win_d;
    logic                   rdy_q, err_q, rstn_q, en_q, ov_q, busy_q;
    logic                   take, legal;
    logic [CNT_W-1:0]       warm_last;

    always_comb begin
        take      = cfg_valid && !rdy_q;
        legal     = (cfg_window == '0) ||
                    (cfg_window <= SIZE_WINDOW'(MAX_WINDOW) && (cfg_window & (cfg_window - 1'b1)) == '0);
        warm_last = CNT_W'(win_q) + CNT_W'(PIPE_LAT - 1);
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        case (state_q)
            FLUSH: begin
                state_d = (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) ? WARMUP : FLUSH;
                cnt_d   = (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
            end
            WARMUP: begin
                state_d = (cnt_q == warm_last) ? RUN : WARMUP;
                cnt_d   = (cnt_q == warm_last) ? '0 : cnt_q + 1'b1;
            end
            default: ;
        endcase
        // A legal request overrides any pending phase change, restarting the flush at full length.
        if (take && legal) begin
            win_d   = cfg_window;
            state_d = (cfg_window == '0) ? IDLE : FLUSH;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rstn_q  <= 1'b0;
            en_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            rdy_q   <= take;
            err_q   <= take && !legal;
            rstn_q  <= (state_d == WARMUP) || (state_d == RUN);
            en_q    <= (state_d == RUN) && in_valid;
            ov_q    <= (state_d == RUN) && en_q;
            busy_q  <= (state_d == FLUSH) || (state_d == WARMUP);
        end
    end

    assign state        = state_q;
    assign cfg_ready    = rdy_q;
    assign cfg_error    = err_q;
    assign filt_reset_n = rstn_q;
    assign filt_window  = win_q;
    assign filt_enable  = en_q;
    assign out_valid    = ov_q;
    assign busy         = busy_q;
endmodule
